// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter
// Shares one 32-bit memory port between instruction fetch and load/store.
// One transaction is outstanding at a time: IDLE -> BUSY -> RESP -> IDLE.
// Arbitration is round-robin. last_grant resets to fetch, so data wins the
// first contest after reset. Every output comes straight from a flop.
module fwrisc_mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              ivalid,
   output logic              iready,
   output logic [31:0]       idata,
   input  logic [ADDR_W-1:0] daddr,
   input  logic              dvalid,
   input  logic              dwrite,
   input  logic [31:0]       dwdata,
   input  logic [3:0]        dwstb,
   output logic              dready,
   output logic [31:0]       drdata,
   output logic [ADDR_W-1:0] maddr,
   output logic              mvalid,
   output logic              mwrite,
   output logic [31:0]       mwdata,
   output logic [3:0]        mwstb,
   input  logic              mready,
   input  logic [31:0]       mrdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;   // 1 = data, 0 = fetch
   logic              owner_q, owner_d;             // 1 = data, 0 = fetch
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic              mvalid_q, mvalid_d;
   logic              mwrite_q, mwrite_d;
   logic [31:0]       mwdata_q, mwdata_d;
   logic [3:0]        mwstb_q, mwstb_d;
   logic              iready_q, iready_d;
   logic              dready_q, dready_d;
   logic [31:0]       idata_q, idata_d;
   logic [31:0]       drdata_q, drdata_d;
   logic              grant_data_s;

   // Data wins when it is the only requester, or in a contest after a fetch grant
   assign grant_data_s = dvalid & (~ivalid | ~last_grant_q);

   // Next-state and next-output logic of the transaction FSM
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      maddr_d      = maddr_q;
      mvalid_d     = mvalid_q;
      mwrite_d     = mwrite_q;
      mwdata_d     = mwdata_q;
      mwstb_d      = mwstb_q;
      iready_d     = 1'b0;
      dready_d     = 1'b0;
      idata_d      = idata_q;
      drdata_d     = drdata_q;

      case (state_q)
         ST_IDLE: begin
            if (ivalid | dvalid) begin
               state_d      = ST_BUSY;
               mvalid_d     = 1'b1;
               owner_d      = grant_data_s;
               last_grant_d = grant_data_s;
               if (grant_data_s) begin
                  maddr_d  = daddr;
                  mwrite_d = dwrite;
                  mwdata_d = dwdata;
                  mwstb_d  = dwstb;
               end else begin
                  maddr_d  = iaddr;
                  mwrite_d = 1'b0;
                  mwdata_d = 32'h0000_0000;
                  mwstb_d  = 4'b0000;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mready) begin
               state_d  = ST_RESP;
               mvalid_d = 1'b0;
               if (owner_q) begin
                  drdata_d = mrdata;
                  dready_d = 1'b1;
               end else begin
                  idata_d  = mrdata;
                  iready_d = 1'b1;
               end
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_RESP: begin
            // Requester sees ready this cycle; no grant until the next IDLE
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            mvalid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b0;
         owner_q      <= 1'b0;
         maddr_q      <= {ADDR_W{1'b0}};
         mvalid_q     <= 1'b0;
         mwrite_q     <= 1'b0;
         mwdata_q     <= 32'h0000_0000;
         mwstb_q      <= 4'b0000;
         iready_q     <= 1'b0;
         dready_q     <= 1'b0;
         idata_q      <= 32'h0000_0000;
         drdata_q     <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         maddr_q      <= maddr_d;
         mvalid_q     <= mvalid_d;
         mwrite_q     <= mwrite_d;
         mwdata_q     <= mwdata_d;
         mwstb_q      <= mwstb_d;
         iready_q     <= iready_d;
         dready_q     <= dready_d;
         idata_q      <= idata_d;
         drdata_q     <= drdata_d;
      end
   end

   assign maddr  = maddr_q;
   assign mvalid = mvalid_q;
   assign mwrite = mwrite_q;
   assign mwdata = mwdata_q;
   assign mwstb  = mwstb_q;
   assign iready = iready_q;
   assign dready = dready_q;
   assign idata  = idata_q;
   assign drdata = drdata_q;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Testbench for fwrisc_mem_arbiter.
// A reference model pushes the expected grant and response for every
// request it sees sampled in IDLE. A negedge monitor pops and compares them
// when mvalid rises and when a ready pulse appears.
module tb_fwrisc_mem_arbiter;

   typedef struct {
      logic        is_data;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  stb;
      logic [31:0] rdata;
   } txn_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] iaddr = 32'h0;
   logic        ivalid = 1'b0;
   logic        iready;
   logic [31:0] idata;
   logic [31:0] daddr = 32'h0;
   logic        dvalid = 1'b0;
   logic        dwrite = 1'b0;
   logic [31:0] dwdata = 32'h0;
   logic [3:0]  dwstb = 4'b0000;
   logic        dready;
   logic [31:0] drdata;
   logic [31:0] maddr;
   logic        mvalid;
   logic        mwrite;
   logic [31:0] mwdata;
   logic [3:0]  mwstb;
   logic        mready = 1'b0;
   logic [31:0] mrdata = 32'h0;

   int n_vec = 0;
   int n_err = 0;

   txn_t exp_grant[$];
   txn_t exp_resp[$];
   logic resp_log[$];

   // stimulus tables consumed by run_traffic
   logic [31:0] f_addr[8];
   logic [31:0] d_addr[8];
   logic        d_wr[8];
   logic [31:0] d_wdata[8];
   logic [3:0]  d_stb[8];
   int          nf = 0;
   int          nd = 0;

   // memory model controls
   int mem_wait = 0;
   bit mem_tie = 1'b0;
   int busy_cnt = 0;
   bit chk_spacing = 1'b0;

   // monitor state
   logic        mv_prev = 1'b0;
   logic [31:0] lat_addr, lat_wdata;
   logic        lat_wr;
   logic [3:0]  lat_stb;
   int          cyc = 0;
   int          last_i_cyc = -1;

   // reference model state
   logic [1:0]  m_st = 2'd0;
   logic        m_last = 1'b0;
   logic        m_win;

   fwrisc_mem_arbiter #(.ADDR_W(32)) dut (
      .clock(clock), .reset(reset),
      .iaddr(iaddr), .ivalid(ivalid), .iready(iready), .idata(idata),
      .daddr(daddr), .dvalid(dvalid), .dwrite(dwrite), .dwdata(dwdata),
      .dwstb(dwstb), .dready(dready), .drdata(drdata),
      .maddr(maddr), .mvalid(mvalid), .mwrite(mwrite), .mwdata(mwdata),
      .mwstb(mwstb), .mready(mready), .mrdata(mrdata)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_func(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0000_0013;
      return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic txn_t make_txn(input logic win_d);
      txn_t t;
      t.is_data = win_d;
      t.addr    = win_d ? daddr : iaddr;
      t.wr      = win_d ? dwrite : 1'b0;
      t.wdata   = win_d ? dwdata : 32'h0;
      t.stb     = win_d ? dwstb : 4'b0000;
      t.rdata   = mem_func(t.addr);
      return t;
   endfunction

   // Expected winner of an IDLE-cycle contest
   assign m_win = dvalid && (!ivalid || !m_last);

   // Reference model: predicts grants from sampled requests and pushes expectations
   always @(posedge clock) begin
      if (reset) begin
         m_st   <= 2'd0;
         m_last <= 1'b0;
         exp_grant.delete();
         exp_resp.delete();
      end else begin
         case (m_st)
            2'd0: if (ivalid || dvalid) begin
               exp_grant.push_back(make_txn(m_win));
               exp_resp.push_back(make_txn(m_win));
               m_last <= m_win;
               m_st   <= 2'd1;
            end
            2'd1: if (mready) m_st <= 2'd2;
            2'd2: m_st <= 2'd0;
            default: m_st <= 2'd0;
         endcase
      end
   end

   // Memory model: mready after mem_wait BUSY cycles, data from mem_func
   always @(negedge clock) begin
      if (!mvalid) begin
         busy_cnt = 0;
         mready   = mem_tie;
      end else begin
         busy_cnt = busy_cnt + 1;
         mready   = mem_tie || (busy_cnt > mem_wait);
      end
      mrdata = mem_func(maddr);
   end

   // Monitor: compare grants, stability while BUSY, and responses
   always @(negedge clock) begin
      txn_t g;
      txn_t r;
      cyc <= cyc + 1;
      if (!chk_spacing) last_i_cyc <= -1;
      if (mvalid && !mv_prev) begin
         if (exp_grant.size() == 0) begin
            check_eq("unexpected_grant", 32'(mvalid), 32'(1'b0));
         end else begin
            g = exp_grant.pop_front();
            check_eq("maddr", maddr, g.addr);
            check_eq("mwrite", 32'(mwrite), 32'(g.wr));
            check_eq("mwstb", 32'(mwstb), 32'(g.stb));
            if (g.is_data) check_eq("mwdata", mwdata, g.wdata);
         end
         lat_addr  <= maddr;
         lat_wr    <= mwrite;
         lat_wdata <= mwdata;
         lat_stb   <= mwstb;
      end else if (mvalid && mv_prev) begin
         check_eq("stable_maddr", maddr, lat_addr);
         check_eq("stable_m", {mwdata[27:0], mwstb}, {lat_wdata[27:0], lat_stb});
         check_eq("stable_mwrite", 32'(mwrite), 32'(lat_wr));
      end
      if (iready || dready) begin
         check_eq("both_ready", 32'(iready && dready), 32'(1'b0));
         check_eq("ready_after_busy", 32'({mv_prev, mvalid}), 32'(2'b10));
         if (exp_resp.size() == 0) begin
            check_eq("unexpected_ready", 32'({iready, dready}), 32'(2'b00));
         end else begin
            r = exp_resp.pop_front();
            check_eq("ready_owner", 32'(dready), 32'(r.is_data));
            if (r.is_data) check_eq("drdata", drdata, r.rdata);
            else check_eq("idata", idata, r.rdata);
         end
         resp_log.push_back(dready);
         if (iready) begin
            if (chk_spacing && last_i_cyc >= 0) check_eq("iready_spacing", 32'(cyc - last_i_cyc), 32'd3);
            last_i_cyc <= cyc;
         end
      end
      mv_prev <= mvalid;
   end

   // Drive the request tables until every request has seen its ready
   task automatic run_traffic(input int budget);
      int  fi = 0;
      int  di = 0;
      bit  done = 1'b0;
      for (int n = 0; n < budget; n++) begin
         ivalid = (fi < nf);
         iaddr  = (fi < nf) ? f_addr[fi] : 32'h0;
         dvalid = (di < nd);
         if (di < nd) begin
            daddr  = d_addr[di];
            dwrite = d_wr[di];
            dwdata = d_wdata[di];
            dwstb  = d_stb[di];
         end else begin
            daddr  = 32'h0;
            dwrite = 1'b0;
            dwdata = 32'h0;
            dwstb  = 4'b0000;
         end
         done = (fi >= nf) && (di >= nd);
         if (done) break;
         @(negedge clock);
         if (iready) fi++;
         if (dready) di++;
      end
      check_eq("run_done", 32'(done), 32'd1);
      repeat (2) @(negedge clock);
      check_eq("sb_empty", 32'(exp_grant.size() + exp_resp.size()), 32'd0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int base;
      bit seen;
      // reset values
      repeat (2) @(negedge clock);
      check_eq("rst_mvalid", 32'(mvalid), 32'd0);
      check_eq("rst_mwrite", 32'(mwrite), 32'd0);
      check_eq("rst_maddr", maddr, 32'h0);
      check_eq("rst_mwdata", mwdata, 32'h0);
      check_eq("rst_mwstb", 32'(mwstb), 32'd0);
      check_eq("rst_iready", 32'(iready), 32'd0);
      check_eq("rst_dready", 32'(dready), 32'd0);
      check_eq("rst_idata", idata, 32'h0);
      check_eq("rst_drdata", drdata, 32'h0);
      reset = 1'b0;

      // single fetch, mready tied high (ignored outside BUSY)
      mem_tie = 1'b1; mem_wait = 0;
      nf = 1; nd = 0; f_addr[0] = 32'h0000_0100;
      run_traffic(20);
      check_eq("fetch_idata_held", idata, 32'h0000_0013);

      // store with three wait cycles
      mem_tie = 1'b0; mem_wait = 3;
      nf = 0; nd = 1;
      d_addr[0] = 32'h0000_2004; d_wr[0] = 1'b1; d_wdata[0] = 32'hDEAD_BEEF; d_stb[0] = 4'b0011;
      run_traffic(30);
      check_eq("idata_untouched", idata, 32'h0000_0013);

      // contention straight out of reset: D, I, D, I
      apply_reset();
      mem_wait = 0;
      nf = 2; f_addr[0] = 32'h0000_0300; f_addr[1] = 32'h0000_0304;
      nd = 2;
      d_addr[0] = 32'h0000_1000; d_wr[0] = 1'b0; d_wdata[0] = 32'h0; d_stb[0] = 4'b0000;
      d_addr[1] = 32'h0000_1004; d_wr[1] = 1'b1; d_wdata[1] = 32'h1234_5678; d_stb[1] = 4'b1111;
      base = resp_log.size();
      run_traffic(40);
      check_eq("contend_count", 32'(resp_log.size() - base), 32'd4);
      if (resp_log.size() - base == 4)
         check_eq("contend_order", 32'({resp_log[base], resp_log[base+1], resp_log[base+2], resp_log[base+3]}), 32'(4'b1010));

      // back-to-back fetches, 3-cycle spacing
      chk_spacing = 1'b1;
      nd = 0; nf = 3;
      f_addr[0] = 32'h0; f_addr[1] = 32'h4; f_addr[2] = 32'h8;
      run_traffic(40);
      chk_spacing = 1'b0;

      // reset while a load is in BUSY
      mem_wait = 5;
      @(negedge clock);
      dvalid = 1'b1; dwrite = 1'b0; daddr = 32'h0000_0040; dwstb = 4'b0000; dwdata = 32'h0;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         if (mvalid) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("rst_busy_seen", 32'(seen), 32'd1);
      reset = 1'b1; dvalid = 1'b0;
      @(negedge clock);
      check_eq("midrst_mvalid", 32'(mvalid), 32'd0);
      check_eq("midrst_dready", 32'(dready), 32'd0);
      check_eq("midrst_drdata", drdata, 32'h0);
      check_eq("midrst_iready", 32'(iready), 32'd0);
      reset = 1'b0;
      mem_wait = 0;
      nf = 1; f_addr[0] = 32'h0000_0500;
      nd = 1; d_addr[0] = 32'h0000_0600; d_wr[0] = 1'b0; d_wdata[0] = 32'h0; d_stb[0] = 4'b0000;
      base = resp_log.size();
      run_traffic(30);
      check_eq("post_rst_count", 32'(resp_log.size() - base), 32'd2);
      if (resp_log.size() - base == 2)
         check_eq("post_rst_order", 32'({resp_log[base], resp_log[base+1]}), 32'(2'b10));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
